// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads,
// and buffers fetched words in a 2-entry prefetch FIFO presented to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_pc;
  logic [1:0]  count;
  logic [31:0] buf_pc_p0, buf_pc_p1;
  logic [31:0] buf_word_p0, buf_word_p1;

  logic        done;
  logic        push;
  logic        pop;
  logic        load_p0;
  logic        shift_p0;
  logic        load_p1;
  logic [1:0]  count_nxt;
  logic [31:0] target;

  always_comb begin
    target    = branch_target & 32'hFFFF_FFFC;
    done      = imem_req && imem_ack;
    pop       = instr_valid && !stall && !branch_valid;
    push      = (state == FETCH) && done && !branch_valid;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    // New word lands at the head when the buffer is (or is becoming) empty.
    load_p0   = push && ((count == 2'd0) || ((count == 2'd1) && pop));
    shift_p0  = pop && !load_p0;
    load_p1   = push && !load_p0;
  end

  assign imem_req    = (state == FETCH) || (state == DISCARD);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? buf_word_p0 : 32'd0;
  assign instr_pc    = buf_pc_p0;
  assign pc_plus8    = buf_pc_p0 + 32'd8;

  // Fetch control: request sequencing and redirect handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (branch_valid) fetch_pc <= target;
        end
        FETCH: begin
          if (branch_valid) begin
            if (done) begin
              fetch_pc <= target;
            end else begin
              redirect_pc <= target;
              state       <= DISCARD;
            end
          end else if (done) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_nxt == 2'd2) state <= HOLD;
          end
        end
        HOLD: begin
          if (branch_valid) begin
            fetch_pc <= target;
            state    <= FETCH;
          end else if (pop) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          // The stale read must complete before the redirect address is issued.
          if (branch_valid) begin
            redirect_pc <= target;
            if (done) begin
              fetch_pc <= target;
              state    <= FETCH;
            end
          end else if (done) begin
            fetch_pc <= redirect_pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch buffer: occupancy and entry PCs
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      buf_pc_p0 <= RESET_PC;
      buf_pc_p1 <= RESET_PC;
    end else begin
      count <= branch_valid ? 2'd0 : count_nxt;
      if (load_p0)       buf_pc_p0 <= fetch_pc;
      else if (shift_p0) buf_pc_p0 <= buf_pc_p1;
      if (load_p1)       buf_pc_p1 <= fetch_pc;
    end
  end

  // Prefetch buffer: instruction words
  always_ff @(posedge clk) begin
    if (load_p0)       buf_word_p0 <= imem_rdata;
    else if (shift_p0) buf_word_p0 <= buf_word_p1;
    if (load_p1)       buf_word_p1 <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  // Model: buffer contents, fetch address, and what the fetcher is currently doing.
  ent_t        q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;
  bit          m_started;
  bit          m_hold;
  bit          m_disc;
  bit          m_jr;
  int          mwait;
  int          cur_lat;
  int          fixed_lat;
  logic [31:0] saved;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic bit m_req();
    return m_started && !m_hold;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req() || m_jr) chk("imem_addr", imem_addr, m_fpc);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr", instr, q[0].w);
      chk("instr_pc", instr_pc, q[0].pc);
      chk("pc_plus8", pc_plus8, q[0].pc + 32'd8);
    end else if (m_jr) begin
      chk("instr_rst", instr, 32'd0);
      chk("instr_pc_rst", instr_pc, RPC);
      chk("pc_plus8_rst", pc_plus8, RPC + 32'd8);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model, advance DUT.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    bit          req;
    bit          ack;
    bit          done;
    bit          pop;
    logic [31:0] tg;
    check_outputs();
    req = m_req();
    if (req && mwait == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    if (req) ack = (mwait >= cur_lat);
    else     ack = (fixed_lat < 0) && ($urandom_range(0, 1) == 1);
    rst           = r;
    stall         = s;
    branch_valid  = b;
    branch_target = t;
    imem_ack      = ack;
    imem_rdata    = (req && ack) ? mem_word(m_fpc) : $urandom();
    if (r || !req || ack) mwait = 0;
    else mwait++;
    if (r) begin
      q.delete();
      m_fpc = RPC; m_rpc = RPC;
      m_started = 0; m_hold = 0; m_disc = 0; m_jr = 1;
    end else begin
      m_jr = 0;
      done = req && ack;
      tg   = t & 32'hFFFF_FFFC;
      pop  = (q.size() != 0) && !s && !b;
      if (b) begin
        q.delete();
        if (!m_started) begin
          m_fpc = tg; m_started = 1;
        end else if (m_hold) begin
          m_fpc = tg; m_hold = 0;
        end else if (m_disc) begin
          m_rpc = tg;
          if (done) begin m_fpc = tg; m_disc = 0; end
        end else if (done) begin
          m_fpc = tg;
        end else begin
          m_rpc = tg; m_disc = 1;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (!m_started) begin
          m_started = 1;
        end else if (m_hold) begin
          if (pop) m_hold = 0;
        end else if (m_disc) begin
          if (done) begin m_fpc = m_rpc; m_disc = 0; end
        end else if (done) begin
          q.push_back('{pc: m_fpc, w: imem_rdata});
          m_fpc = m_fpc + 32'd4;
          if (q.size() == 2) m_hold = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic find_fresh();
    for (int i = 0; i < 20 && !(m_req() && mwait == 0); i++) step(0, 0, 0, 32'd0);
    chk("fresh_req_found", 32'(m_req() && mwait == 0), 32'd1);
  endtask

  task automatic reset_literals();
    chk("lit_rst_req", 32'(imem_req), 32'd0);
    chk("lit_rst_addr", imem_addr, 32'h100);
    chk("lit_rst_valid", 32'(instr_valid), 32'd0);
    chk("lit_rst_instr", instr, 32'd0);
    chk("lit_rst_pc", instr_pc, 32'h100);
    chk("lit_rst_pc8", pc_plus8, 32'h108);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    m_fpc = RPC; m_rpc = RPC; m_started = 0; m_hold = 0; m_disc = 0; m_jr = 1;
    mwait = 0; cur_lat = 0; fixed_lat = 0;
    @(posedge clk);
    #1;
    reset_literals();

    // Stream with same-cycle acks
    step(0, 0, 0, 32'd0);
    chk("lit_first_req", 32'(imem_req), 32'd1);
    chk("lit_first_addr", imem_addr, 32'h100);
    step(0, 0, 0, 32'd0);
    chk("lit_s0_pc", instr_pc, 32'h100);
    chk("lit_s0_pc8", pc_plus8, 32'h108);
    step(0, 0, 0, 32'd0);
    chk("lit_s1_pc", instr_pc, 32'h104);
    chk("lit_s1_pc8", pc_plus8, 32'h10C);
    step(0, 0, 0, 32'd0);
    chk("lit_s2_pc", instr_pc, 32'h108);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'd0);

    // Back-pressure
    saved = instr_pc;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'd0);
    chk("lit_hold_req", 32'(imem_req), 32'd0);
    chk("lit_hold_pc", instr_pc, saved);
    step(0, 0, 0, 32'd0);
    chk("lit_release_pc", instr_pc, saved + 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'd0);

    // Branch with an in-flight read
    fixed_lat = 3;
    find_fresh();
    saved = imem_addr;
    step(0, 0, 0, 32'd0);
    step(0, 0, 1, 32'h2000);
    chk("lit_disc_addr0", imem_addr, saved);
    chk("lit_disc_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 32'd0);
    chk("lit_disc_addr1", imem_addr, saved);
    step(0, 0, 0, 32'd0);
    chk("lit_redirect_addr", imem_addr, 32'h2000);
    chk("lit_redirect_valid", 32'(instr_valid), 32'd0);

    // Double redirect
    find_fresh();
    step(0, 0, 1, 32'h3000);
    step(0, 0, 1, 32'h4000);
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    chk("lit_double_addr", imem_addr, 32'h4000);

    // Branch colliding with a completion while a pop is pending
    fixed_lat = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'd0);
    chk("lit_coll_pre_valid", 32'(instr_valid), 32'd1);
    step(0, 0, 1, 32'h5000);
    chk("lit_coll_valid", 32'(instr_valid), 32'd0);
    chk("lit_coll_addr", imem_addr, 32'h5000);

    // Address wrap
    step(0, 0, 1, 32'hFFFF_FFFB);
    chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 32'd0);
    chk("lit_wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    chk("lit_wrap_p80", pc_plus8, 32'h0);
    step(0, 0, 0, 32'd0);
    chk("lit_wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_p81", pc_plus8, 32'h4);
    step(0, 0, 0, 32'd0);
    chk("lit_wrap_pc2", instr_pc, 32'h0);
    chk("lit_wrap_p82", pc_plus8, 32'h8);

    // Reset with a read outstanding
    fixed_lat = 3;
    find_fresh();
    step(0, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    reset_literals();
    step(0, 0, 0, 32'd0);
    chk("lit_rerst_req", 32'(imem_req), 32'd1);
    chk("lit_rerst_addr", imem_addr, 32'h100);

    // Randomized traffic
    fixed_lat = -1;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 6), $urandom());
    end
    step(0, 0, 0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
